// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment
// patterns, off codes and the per-digit display record.
package seg7_pkg;

   localparam int unsigned MAX_DIG = 8;
   localparam int unsigned DATA_W  = 4 * MAX_DIG;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   // Active-low gfedcba patterns, entry 0 is the rightmost element
   localparam logic [15:0][6:0] HEX_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [MAX_DIG-1:0] dp;
      logic [MAX_DIG-1:0] blank;
      logic [MAX_DIG-1:0] blink;
   } disp_t;

   // Everything blanked so nothing lights before the first committed load
   localparam disp_t DISP_RST = '{data: '0, dp: '0, blank: '1, blink: '0};

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex code to active-low segment pattern lookup.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg_c
);

   always_comb seg_c = HEX_TABLE[code];

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed seven-segment scanner with double-buffered digit contents
// committed on frame boundaries, per-digit blanking and blinking.
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int unsigned NDIG         = 8,
   parameter int unsigned SCAN_DIV     = 100_000,
   parameter int unsigned BLINK_FRAMES = 250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4*NDIG-1:0] data,
   input  logic [NDIG-1:0]   dp,
   input  logic [NDIG-1:0]   blank,
   input  logic [NDIG-1:0]   blink,
   input  logic              load,
   output logic              pend,
   output logic              frame_done,
   output logic [7:0]        SEG,
   output logic [7:0]        AN
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned IW = 3;

   logic [PW-1:0] presc;
   logic [IW-1:0] idx;
   logic [BW-1:0] bcnt;
   logic          phase_off;
   disp_t         shadow;
   disp_t         active;

   disp_t      cap_c;
   logic       tick_c;
   logic       wrap_c;
   logic       dark_c;
   logic [3:0] code_c;
   logic [6:0] hex_c;

   // Inputs widened to the full-size record; unused digit slots stay zero
   always_comb begin
      cap_c       = DISP_RST;
      cap_c.data  = DATA_W'(data);
      cap_c.dp    = MAX_DIG'(dp);
      cap_c.blank = MAX_DIG'(blank);
      cap_c.blink = MAX_DIG'(blink);
   end

   always_comb begin
      tick_c     = (presc == PW'(SCAN_DIV - 1));
      wrap_c     = tick_c && (idx == IW'(NDIG - 1));
      frame_done = wrap_c && !rst;
      code_c     = active.data[{idx, 2'b00} +: 4];
      dark_c     = active.blank[idx] | (active.blink[idx] & phase_off);
   end

   seg7_decode u_decode (
      .code  (code_c),
      .seg_c (hex_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         idx       <= '0;
         bcnt      <= '0;
         phase_off <= 1'b0;
         pend      <= 1'b0;
         shadow    <= DISP_RST;
         active    <= DISP_RST;
         SEG       <= SEG_OFF;
         AN        <= AN_OFF;
      end else begin
         presc <= tick_c ? '0 : presc + PW'(1);
         if (tick_c) idx <= wrap_c ? '0 : idx + IW'(1);

         if (wrap_c) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
               bcnt      <= '0;
               phase_off <= ~phase_off;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
            // A load coinciding with the wrap bypasses the shadow wait
            pend <= 1'b0;
            if (load) begin
               active <= cap_c;
               shadow <= cap_c;
            end else if (pend) begin
               active <= shadow;
            end
         end else if (load) begin
            shadow <= cap_c;
            pend   <= 1'b1;
         end

         if (dark_c) begin
            SEG <= SEG_OFF;
            AN  <= AN_OFF;
         end else begin
            SEG <= {~active.dp[idx], hex_c};
            AN  <= AN_OFF & ~(8'(1) << idx);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed self-checking bench for seg7_scanner (4 digits, 4-cycle dwell,
// 2-frame blink half-period).
module tb_seg7_scanner;

   localparam int unsigned NDIG         = 4;
   localparam int unsigned SCAN_DIV     = 4;
   localparam int unsigned BLINK_FRAMES = 2;

   localparam logic [3:0][7:0] AN_SCAN = {8'hF7, 8'hFB, 8'hFD, 8'hFE};
   localparam logic [3:0][7:0] DARK    = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
   localparam logic [3:0][7:0] S3210   = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
   localparam logic [3:0][7:0] SFEDC   = {8'h8E, 8'h86, 8'hA1, 8'hC6};
   localparam logic [3:0][7:0] S5678   = {8'h92, 8'h02, 8'hF8, 8'hFF};
   localparam logic [3:0][7:0] A5678   = {8'hF7, 8'hFB, 8'hFD, 8'hFF};
   localparam logic [3:0][7:0] S4321   = {8'h99, 8'hB0, 8'hA4, 8'hF9};

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data;
   logic [3:0]  dp, blank, blink;
   logic        load;
   logic        pend, frame_done;
   logic [7:0]  SEG, AN;

   logic [15:0] n_data;
   logic [3:0]  n_dp, n_blank, n_blink;

   int errs   = 0;
   int checks = 0;
   int wraps  = 0;

   always #5 clk = ~clk;

   seg7_scanner #(
      .NDIG         (NDIG),
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .dp         (dp),
      .blank      (blank),
      .blink      (blink),
      .load       (load),
      .pend       (pend),
      .frame_done (frame_done),
      .SEG        (SEG),
      .AN         (AN)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Garbage on the data inputs without load must never reach the display
   task automatic scramble();
      data  = 16'($urandom);
      dp    = 4'($urandom);
      blank = 4'($urandom);
      blink = 4'($urandom);
      load  = 1'b0;
   endtask

   task automatic apply_next();
      data  = n_data;
      dp    = n_dp;
      blank = n_blank;
      blink = n_blink;
      load  = 1'b1;
   endtask

   task automatic wait_wrap(input string tag, input int n0, input int exp_n);
      int n = n0;
      while (frame_done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({tag, " wrap_cycles"}, 32'(n), 32'(exp_n));
   endtask

   // Starts on a frame_done sample, scans one frame, ends on the next one.
   // ld_off >= 0 drives a load in the cycle at that offset from the wrap.
   task automatic scan_frame(input string tag, input logic [3:0][7:0] es,
                             input logic [3:0][7:0] ea, input int ld_off);
      int k;
      for (int off = 1; off <= 16; off++) begin
         if (off - 1 == ld_off) apply_next();
         else scramble();
         step();
         if (off == 1) check({tag, " pend_after_wrap"}, 32'(pend), 32'd0);
         if (off >= 2) begin
            k = (off - 2) / 4;
            check($sformatf("%s seg d%0d off%0d", tag, k, off), 32'(SEG), 32'(es[k]));
            check($sformatf("%s an d%0d off%0d", tag, k, off), 32'(AN), 32'(ea[k]));
         end
         if (ld_off >= 1 && off == ld_off + 1 && off < 16)
            check({tag, " pend_set"}, 32'(pend), 32'd1);
         if (off == 8) check({tag, " fd_mid"}, 32'(frame_done), 32'd0);
      end
      check({tag, " fd_wrap"}, 32'(frame_done), 32'd1);
      check({tag, " pend_at_wrap"}, 32'(pend), (ld_off >= 1) ? 32'd1 : 32'd0);
      wraps++;
   endtask

   initial begin
      logic [3:0][7:0] es;
      logic [3:0][7:0] ea;

      rst = 1'b1;
      scramble();
      n_data = '0; n_dp = '0; n_blank = '0; n_blink = '0;
      repeat (3) step();
      check("rst seg", 32'(SEG), 32'hFF);
      check("rst an", 32'(AN), 32'hFF);
      check("rst pend", 32'(pend), 32'd0);
      check("rst fd", 32'(frame_done), 32'd0);

      // Release and load in the first cycle; commit waits for the first wrap
      rst = 1'b0;
      n_data = 16'h3210;
      apply_next();
      step();
      scramble();
      check("load pend", 32'(pend), 32'd1);
      check("dark before commit", 32'(AN), 32'hFF);
      wait_wrap("first", 1, 15);
      check("first pend_at_wrap", 32'(pend), 32'd1);
      wraps = 1;

      // Mid-frame load: old digits finish, new ones follow the wrap
      n_data = 16'hFEDC;
      scan_frame("3210", S3210, AN_SCAN, 5);
      scan_frame("FEDC", SFEDC, AN_SCAN, -1);

      // Load coincident with the wrap, with dp and blank
      n_data = 16'h5678; n_dp = 4'b0100; n_blank = 4'b0001; n_blink = 4'b0000;
      scan_frame("dp_blank", S5678, A5678, 0);

      // Digit 3 blinks: two frames lit, two dark
      n_blink = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         es = S5678;
         ea = A5678;
         if (((wraps / 2) % 2) == 1) begin
            es[3] = 8'hFF;
            ea[3] = 8'hFF;
         end
         scan_frame($sformatf("blink%0d", i), es, ea, (i == 0) ? 0 : -1);
      end

      // Reset during digit 2 with an update pending
      scramble();
      repeat (3) step();
      n_data = 16'hAAAA; n_dp = '0; n_blank = '0; n_blink = '0;
      apply_next();
      step();
      scramble();
      check("pre_rst pend", 32'(pend), 32'd1);
      repeat (5) step();
      rst = 1'b1;
      step();
      check("mid_rst seg", 32'(SEG), 32'hFF);
      check("mid_rst an", 32'(AN), 32'hFF);
      check("mid_rst pend", 32'(pend), 32'd0);
      check("mid_rst fd", 32'(frame_done), 32'd0);
      rst = 1'b0;
      wraps = 0;
      wait_wrap("post_rst", 0, 15);
      check("post_rst pend", 32'(pend), 32'd0);
      wraps = 1;

      n_data = 16'h4321;
      scan_frame("dark", DARK, DARK, 8);
      scan_frame("4321", S4321, AN_SCAN, -1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
